pulp_board_reset_ctrl: RTL and testbench

PULP_BOARD_RESET_CTRL -- requirements
Module: pulp_board_reset_ctrl

---
 rtl/pulp_board_reset_pkg.sv | 21 ++
 rtl/pulp_debounce.sv | 71 +++++++
 rtl/pulp_board_reset_ctrl.sv | 137 +++++++++++++
 tb/tb_pulp_board_reset_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulp_board_reset_pkg.sv
// Shared types and constants for the board-level reset controller.
package pulp_board_reset_pkg;

   // Width of the button-triggered reset counter exposed on reset_count_o.
   localparam int RESET_COUNT_W = 8;
   localparam logic [RESET_COUNT_W-1:0] RESET_COUNT_MAX = '1;

   // Reset sequencer states: hold the SoC in reset, wait for the button to be
   // released (and the clock to lock), or let the SoC run.
   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_WAIT_REL = 2'd1,
      ST_RUN      = 2'd2
   } rst_state_e;

   // Increment that sticks at the maximum instead of wrapping.
   function automatic logic [RESET_COUNT_W-1:0] sat_inc(input logic [RESET_COUNT_W-1:0] value);
      return (value == RESET_COUNT_MAX) ? value : value + RESET_COUNT_W'(1);
   endfunction

endpackage

// File: rtl/pulp_debounce.sv
// Input synchronizer followed by a counter-based debouncer. A new level is
// accepted only after it has differed from the current output for
// DEBOUNCE_CYCLES consecutive cycles.
module pulp_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   // chain[0] is the raw pin, chain[SYNC_STAGES] the synchronized level.
   logic [SYNC_STAGES:0] chain;
   assign chain[0] = din;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         logic stage_reg;
         // One synchronizer flop per stage, cleared by reset.
         always_ff @(posedge clk) begin
            if (srst) begin
               stage_reg <= 1'b0;
            end else begin
               stage_reg <= chain[gi];
            end
         end
         assign chain[gi+1] = stage_reg;
      end
   endgenerate

   logic             sync_lvl;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             db_reg, db_next;

   assign sync_lvl = chain[SYNC_STAGES];

   // Count consecutive mismatch cycles; accept the new level at the terminal
   // count so the counter never needs to wrap.
   always_comb begin
      cnt_next = '0;
      db_next  = db_reg;
      if (sync_lvl != db_reg) begin
         if (cnt_reg == CNT_TERM) begin
            db_next  = sync_lvl;
            cnt_next = '0;
         end else begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_reg <= '0;
         db_reg  <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         db_reg  <= db_next;
      end
   end

   assign dout = db_reg;

endmodule

// File: rtl/pulp_board_reset_ctrl.sv
// Board reset controller: debounces the reset button, synchronizes the
// clock-manager lock and sequences a minimum-length active-low SoC reset.
module pulp_board_reset_ctrl
   import pulp_board_reset_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int HOLD_CYCLES     = 1024
) (
   input  logic                     ref_clk_i,
   input  logic                     rst_i,
   input  logic                     pad_reset_i,
   input  logic                     clk_locked_i,
   output logic                     rst_no,
   output logic                     btn_db_o,
   output logic [RESET_COUNT_W-1:0] reset_count_o
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_CYCLES - 1);

   // ------------------------------------------------------------------
   // Button: synchronize and debounce
   // ------------------------------------------------------------------
   logic btn_db;

   pulp_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk  (ref_clk_i),
      .srst (rst_i),
      .din  (pad_reset_i),
      .dout (btn_db)
   );

   // ------------------------------------------------------------------
   // Lock: bare synchronizer chain (lock is a level, no debounce needed)
   // ------------------------------------------------------------------
   logic [SYNC_STAGES:0] lock_chain;
   logic                 lock_sync;
   assign lock_chain[0] = clk_locked_i;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_lock_sync
         logic stage_reg;
         // One synchronizer flop per stage, cleared by reset.
         always_ff @(posedge ref_clk_i) begin
            if (rst_i) begin
               stage_reg <= 1'b0;
            end else begin
               stage_reg <= lock_chain[gi];
            end
         end
         assign lock_chain[gi+1] = stage_reg;
      end
   endgenerate

   assign lock_sync = lock_chain[SYNC_STAGES];

   // ------------------------------------------------------------------
   // Reset sequencer
   // ------------------------------------------------------------------
   rst_state_e               state_reg, state_next;
   logic [HOLD_W-1:0]        hold_cnt_reg, hold_cnt_next;
   logic [RESET_COUNT_W-1:0] count_reg, count_next;
   logic                     btn_prev_reg;
   logic                     rst_n_reg, rst_n_next;
   logic                     btn_rise;
   logic                     release_ok;

   assign btn_rise   = btn_db & ~btn_prev_reg;
   assign release_ok = ~btn_db & lock_sync;

   // Next-state logic. HOLD ignores button/lock until its terminal count so
   // the low time can never be shortened or stretched by input activity.
   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      count_next    = count_reg;
      case (state_reg)
         ST_HOLD: begin
            if (hold_cnt_reg == HOLD_TERM) begin
               hold_cnt_next = '0;
               state_next    = release_ok ? ST_RUN : ST_WAIT_REL;
            end else begin
               hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            end
         end
         ST_WAIT_REL: begin
            if (release_ok) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // A press coinciding with lock loss is still one button event.
            if (btn_rise || !lock_sync) begin
               state_next    = ST_HOLD;
               hold_cnt_next = '0;
               if (btn_rise) begin
                  count_next = sat_inc(count_reg);
               end
            end
         end
         default: begin
            state_next    = ST_HOLD;
            hold_cnt_next = '0;
         end
      endcase
      // Registering the decoded next state keeps rst_no glitch-free and
      // equal to "state register is RUN" every cycle.
      rst_n_next = (state_next == ST_RUN);
   end

   // Sequencer state registers.
   always_ff @(posedge ref_clk_i) begin
      if (rst_i) begin
         state_reg    <= ST_HOLD;
         hold_cnt_reg <= '0;
         count_reg    <= '0;
         btn_prev_reg <= 1'b0;
         rst_n_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         count_reg    <= count_next;
         btn_prev_reg <= btn_db;
         rst_n_reg    <= rst_n_next;
      end
   end

   assign rst_no        = rst_n_reg;
   assign btn_db_o      = btn_db;
   assign reset_count_o = count_reg;

endmodule

// File: tb/tb_pulp_board_reset_ctrl.sv
// Testbench for pulp_board_reset_ctrl: directed scenarios followed by random
// button/lock/reset activity, all compared against a behavioural model.
module tb_pulp_board_reset_ctrl;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int HOLD = 8;

   localparam int M_HOLD = 0;
   localparam int M_WAIT = 1;
   localparam int M_RUN  = 2;

   logic       ref_clk_i = 1'b0;
   logic       rst_i;
   logic       pad_reset_i;
   logic       clk_locked_i;
   logic       rst_no;
   logic       btn_db_o;
   logic [7:0] reset_count_o;

   always #5 ref_clk_i = ~ref_clk_i;

   pulp_board_reset_ctrl #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD)
   ) dut (
      .ref_clk_i     (ref_clk_i),
      .rst_i         (rst_i),
      .pad_reset_i   (pad_reset_i),
      .clk_locked_i  (clk_locked_i),
      .rst_no        (rst_no),
      .btn_db_o      (btn_db_o),
      .reset_count_o (reset_count_o)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Behavioural model: delay lines for the synchronizers, a sliding window of
   // synchronized samples for the debouncer, and a mode/elapsed-time sequencer.
   int  m_mode;
   int  m_elapsed;
   int  m_count;
   bit  m_db;
   bit  m_prev;
   bit  pad_pipe  [SYNC];
   bit  lock_pipe [SYNC];
   bit  win [$];

   task automatic model_edge(input bit r, input bit pad, input bit lock);
      bit sb, lb, db_b, rise, all_diff;
      if (r) begin
         m_mode = M_HOLD; m_elapsed = 0; m_count = 0; m_db = 0; m_prev = 0;
         for (int i = 0; i < SYNC; i++) begin
            pad_pipe[i] = 0; lock_pipe[i] = 0;
         end
         win = {};
      end else begin
         sb = pad_pipe[SYNC-1];
         lb = lock_pipe[SYNC-1];
         for (int i = SYNC-1; i > 0; i--) begin
            pad_pipe[i]  = pad_pipe[i-1];
            lock_pipe[i] = lock_pipe[i-1];
         end
         pad_pipe[0] = pad; lock_pipe[0] = lock;
         db_b = m_db;
         rise = m_db && !m_prev;
         case (m_mode)
            M_HOLD: begin
               if (m_elapsed == HOLD-1) m_mode = (!m_db && lb) ? M_RUN : M_WAIT;
               else m_elapsed++;
            end
            M_WAIT: if (!m_db && lb) m_mode = M_RUN;
            default: begin
               if (rise || !lb) begin
                  m_mode = M_HOLD; m_elapsed = 0;
                  if (rise && m_count < 255) m_count++;
               end
            end
         endcase
         // Debounced level flips once the last DEB samples all disagree with it.
         win.push_back(sb);
         if (win.size() > DEB) void'(win.pop_front());
         if (win.size() == DEB) begin
            all_diff = 1;
            foreach (win[i]) if (win[i] == m_db) all_diff = 0;
            if (all_diff) m_db = !m_db;
         end
         m_prev = db_b;
      end
   endtask

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: got %b, expected %b", tag, cyc, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   // One clock: drive on the falling edge, advance model on the rising edge,
   // compare all outputs 1 ns later.
   task automatic step(input bit r, input bit pad, input bit lock);
      @(negedge ref_clk_i);
      rst_i = r; pad_reset_i = pad; clk_locked_i = lock;
      @(posedge ref_clk_i);
      model_edge(r, pad, lock);
      cyc++;
      #1;
      chk_bit("rst_no", rst_no, (m_mode == M_RUN));
      chk_bit("btn_db_o", btn_db_o, m_db);
      chk_int("reset_count_o", int'(reset_count_o), m_count);
   endtask

   initial begin
      int first_db, first_low, fall_at, rise_at, low_cycles;
      int pad_run, lock_run;
      bit pad_lvl, lock_lvl, r;

      rst_i = 1; pad_reset_i = 0; clk_locked_i = 1;

      // Reset 3 cycles, then exactly 8 low cycles before release.
      for (int i = 0; i < 3; i++) step(1, 0, 1);
      chk_bit("reset_rst_no", rst_no, 1'b0);
      chk_int("reset_count", int'(reset_count_o), 0);
      for (int i = 0; i < 7; i++) step(0, 0, 1);
      chk_bit("hold_still_low", rst_no, 1'b0);
      step(0, 0, 1);
      chk_bit("hold_released", rst_no, 1'b1);
      $display("txn power-on reset: rst_no=%b count=%0d", rst_no, reset_count_o);
      for (int i = 0; i < 4; i++) step(0, 0, 1);

      // Bouncing press never reaches the debounce threshold.
      for (int i = 0; i < 3; i++) step(0, 1, 1);
      for (int i = 0; i < 2; i++) step(0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 1);
      chk_bit("bounce_db", btn_db_o, 1'b0);
      chk_bit("bounce_rst_no", rst_no, 1'b1);
      chk_int("bounce_count", int'(reset_count_o), 0);
      $display("txn bounce: btn_db=%b rst_no=%b", btn_db_o, rst_no);

      // Clean 10-cycle press: debounce latency 6, rst_no falls one cycle later.
      first_db = -1; first_low = -1;
      for (int i = 1; i <= 10; i++) begin
         step(0, 1, 1);
         if (btn_db_o && first_db < 0) first_db = i;
         if (!rst_no && first_low < 0) first_low = i;
      end
      chk_int("press_db_latency", first_db, 6);
      chk_int("press_rst_latency", first_low, 7);
      chk_int("press_count", int'(reset_count_o), 1);
      for (int i = 0; i < 25; i++) step(0, 0, 1);
      chk_bit("press_recovered", rst_no, 1'b1);
      $display("txn short press: db_lat=%0d rst_lat=%0d count=%0d", first_db, first_low, reset_count_o);

      // Long press: sequencer parks in WAIT_REL until the debounced release.
      for (int i = 0; i < 40; i++) step(0, 1, 1);
      chk_bit("long_held_low", rst_no, 1'b0);
      fall_at = -1; rise_at = -1;
      for (int i = 1; i <= 30; i++) begin
         step(0, 0, 1);
         if (!btn_db_o && fall_at < 0) fall_at = i;
         if (rst_no && rise_at < 0) rise_at = i;
      end
      chk_int("long_release_fall", fall_at, 6);
      chk_int("long_release_rise", rise_at, fall_at + 1);
      chk_int("long_count", int'(reset_count_o), 2);
      $display("txn long press: db_fall=%0d rst_rise=%0d", fall_at, rise_at);

      // Single-cycle lock glitch: one full hold, count unchanged.
      step(0, 0, 0);
      low_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 1);
         if (!rst_no) low_cycles++;
      end
      chk_int("lock_glitch_low", low_cycles, 8);
      chk_int("lock_glitch_count", int'(reset_count_o), 2);
      $display("txn lock glitch: low=%0d", low_cycles);

      // Lock held low: reset held indefinitely, released after relock.
      for (int i = 0; i < 40; i++) step(0, 0, 0);
      chk_bit("lock_lost_low", rst_no, 1'b0);
      for (int i = 0; i < 20; i++) step(0, 0, 1);
      chk_bit("lock_regained", rst_no, 1'b1);
      $display("txn lock lost: rst_no=%b", rst_no);

      // Reset pulse at hold count 5 restarts a full hold.
      for (int i = 0; i < 3; i++) step(1, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 1);
      step(1, 0, 1);
      for (int i = 0; i < 7; i++) step(0, 0, 1);
      chk_bit("restart_still_low", rst_no, 1'b0);
      step(0, 0, 1);
      chk_bit("restart_released", rst_no, 1'b1);
      chk_int("restart_count", int'(reset_count_o), 0);
      $display("txn reset restart: rst_no=%b", rst_no);

      // Random button runs, lock glitches and rare resets.
      pad_run = 0; lock_run = 0; pad_lvl = 0;
      for (int i = 0; i < 1500; i++) begin
         if (pad_run == 0) begin
            pad_lvl = 1'($urandom_range(0, 1));
            pad_run = $urandom_range(1, 12);
         end
         pad_run--;
         if (lock_run > 0) begin
            lock_lvl = 0; lock_run--;
         end else begin
            lock_lvl = 1;
            if ($urandom_range(0, 199) == 0) lock_run = $urandom_range(1, 3);
         end
         r = ($urandom_range(0, 599) == 0);
         step(r, pad_lvl, lock_lvl);
      end
      $display("txn random mix: count=%0d rst_no=%b", reset_count_o, rst_no);

      // Saturation: 260 clean presses from a cleared counter.
      for (int i = 0; i < 2; i++) step(1, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 0, 1);
      for (int p = 0; p < 260; p++) begin
         int hi_len, lo_len;
         hi_len = $urandom_range(5, 12);
         lo_len = $urandom_range(20, 26);
         for (int i = 0; i < hi_len; i++) step(0, 1, 1);
         for (int i = 0; i < lo_len; i++) step(0, 0, 1);
         $display("txn press %0d: len=%0d count=%0d", p, hi_len, reset_count_o);
      end
      chk_int("saturated_count", int'(reset_count_o), 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
